br_resolve_unit: RTL and testbench

//  Parametrised, registered branch-resolution stage; successor to the combinational branch comparator.
//  - Decodes all six RV branch conditions from funct3.
//  - Computes taken, target and mispredict against the front-end prediction.
//  - Holds the result in a one-entry valid/ready output register.
//  - Keeps saturating branch and mispredict counters.

---
 rtl/br_resolve_unit.sv | 107 ++++++++++
 tb/tb_br_resolve_unit.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/br_resolve_unit.sv
// Registered branch-resolution stage: decodes the RV branch condition, computes taken/target/mispredict,
// holds the result in a one-entry valid/ready register and keeps saturating branch/mispredict counters.
module br_resolve_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [XLEN-1:0]  rs1_data_i,
    input  logic [XLEN-1:0]  rs2_data_i,
    input  logic [2:0]       funct3_i,
    input  logic [XLEN-1:0]  pc_i,
    input  logic [XLEN-1:0]  imm_i,
    input  logic             pred_taken_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic             taken_o,
    output logic [XLEN-1:0]  target_o,
    output logic             mispredict_o,
    output logic             br_less_o,
    output logic             br_equal_o,
    output logic             illegal_o,
    output logic [CNT_W-1:0] br_count_o,
    output logic [CNT_W-1:0] mispred_count_o
);

    typedef struct packed {
        logic            taken;
        logic [XLEN-1:0] target;
        logic            mispredict;
        logic            br_less;
        logic            br_equal;
        logic            illegal;
    } res_t;

    res_t             res_d, res_q;
    logic             valid_q;
    logic             eq, slt, ult;
    logic             accept, out_hs;
    logic [CNT_W-1:0] br_cnt_q, mis_cnt_q;

    assign in_ready_o = !rst_i && !flush_i && (!valid_q || out_ready_i);
    assign accept     = in_valid_i && in_ready_o;
    assign out_hs     = valid_q && out_ready_i && !rst_i;

    always_comb begin
        eq  = (rs1_data_i == rs2_data_i);
        slt = ($signed(rs1_data_i) < $signed(rs2_data_i));
        ult = (rs1_data_i < rs2_data_i);

        res_d          = '0;
        res_d.br_equal = eq;
        // Illegal codes fall back to the unsigned compare so br_less is always defined.
        res_d.br_less  = (funct3_i[2:1] == 2'b10) ? slt : ult;
        res_d.illegal  = (funct3_i[2:1] == 2'b01);
        case (funct3_i)
            3'b000:  res_d.taken = eq;
            3'b001:  res_d.taken = !eq;
            3'b100:  res_d.taken = slt;
            3'b101:  res_d.taken = !slt;
            3'b110:  res_d.taken = ult;
            3'b111:  res_d.taken = !ult;
            default: res_d.taken = 1'b0;
        endcase
        res_d.target     = res_d.taken ? (pc_i + imm_i) : (pc_i + XLEN'(4));
        res_d.mispredict = !res_d.illegal && (res_d.taken != pred_taken_i);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            res_q   <= '0;
        end else if (accept) begin
            valid_q <= 1'b1;
            res_q   <= res_d;
        end else if (flush_i || out_hs) begin
            valid_q <= 1'b0;
        end
    end

    // A consume in the flush cycle still counts; flush only discards the entry.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            br_cnt_q  <= '0;
            mis_cnt_q <= '0;
        end else if (out_hs && !res_q.illegal) begin
            if (br_cnt_q != '1)
                br_cnt_q <= br_cnt_q + CNT_W'(1);
            if (res_q.mispredict && (mis_cnt_q != '1))
                mis_cnt_q <= mis_cnt_q + CNT_W'(1);
        end
    end

    assign out_valid_o     = valid_q;
    assign taken_o         = res_q.taken;
    assign target_o        = res_q.target;
    assign mispredict_o    = res_q.mispredict;
    assign br_less_o       = res_q.br_less;
    assign br_equal_o      = res_q.br_equal;
    assign illegal_o       = res_q.illegal;
    assign br_count_o      = br_cnt_q;
    assign mispred_count_o = mis_cnt_q;

endmodule

// File: tb/tb_br_resolve_unit.sv
// Bench for br_resolve_unit: directed scenarios plus a randomized run against a behavioural model.
module tb_br_resolve_unit;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready, pred;
    logic [31:0] rs1, rs2, pc, imm;
    logic [2:0]  f3;

    logic        in_ready, out_valid, taken, mispred, br_less, br_equal, illegal;
    logic [31:0] target, br_cnt, mis_cnt;

    logic        s_in_ready, s_out_valid, s_taken, s_mispred, s_less, s_equal, s_illegal;
    logic [31:0] s_target;
    logic [1:0]  s_br_cnt, s_mis_cnt;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    br_resolve_unit #(.XLEN(32), .CNT_W(32)) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .rs1_data_i(rs1), .rs2_data_i(rs2), .funct3_i(f3), .pc_i(pc), .imm_i(imm),
        .pred_taken_i(pred), .out_valid_o(out_valid), .out_ready_i(out_ready),
        .taken_o(taken), .target_o(target), .mispredict_o(mispred), .br_less_o(br_less),
        .br_equal_o(br_equal), .illegal_o(illegal), .br_count_o(br_cnt), .mispred_count_o(mis_cnt)
    );

    br_resolve_unit #(.XLEN(32), .CNT_W(2)) dut_sat (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(s_in_ready),
        .rs1_data_i(rs1), .rs2_data_i(rs2), .funct3_i(f3), .pc_i(pc), .imm_i(imm),
        .pred_taken_i(pred), .out_valid_o(s_out_valid), .out_ready_i(out_ready),
        .taken_o(s_taken), .target_o(s_target), .mispredict_o(s_mispred), .br_less_o(s_less),
        .br_equal_o(s_equal), .illegal_o(s_illegal), .br_count_o(s_br_cnt), .mispred_count_o(s_mis_cnt)
    );

    // {out_valid, taken, target, mispredict, br_less, br_equal, illegal}
    wire [37:0] obs = {out_valid, taken, target, mispred, br_less, br_equal, illegal};

    // Reference: {taken, target, mispredict, br_less, br_equal, illegal}
    function automatic logic [36:0] ref_res(input logic [2:0] fn, input logic [31:0] a, b, p, im,
                                            input logic pr);
        logic e, lt_s, lt_u, t, ill, less;
        logic [31:0] tgt;
        e    = (a == b);
        lt_s = ($signed(a) < $signed(b));
        lt_u = (a < b);
        ill  = (fn == 3'd2) || (fn == 3'd3);
        case (fn)
            3'd0: t = e;     3'd1: t = !e;
            3'd4: t = lt_s;  3'd5: t = !lt_s;
            3'd6: t = lt_u;  3'd7: t = !lt_u;
            default: t = 1'b0;
        endcase
        less = (fn == 3'd4 || fn == 3'd5) ? lt_s : lt_u;
        tgt  = t ? p + im : p + 32'd4;
        return {t, tgt, !ill && (t != pr), less, e, ill};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [2:0] fn, input logic [31:0] a, b, p, im, input logic pr);
        f3 = fn; rs1 = a; rs2 = b; pc = p; imm = im; pred = pr;
    endtask

    task automatic do_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        set_op(3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        rst = 1'b1; out_ready = 1'b1;
        #1;
        total++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready got=%b exp=0", in_ready); else passed++;
        tick();
        total++; if (obs !== 38'd0) $display("FAIL reset_outputs got=%h exp=0", obs); else passed++;
        total++; if ({br_cnt, mis_cnt} !== 64'd0) $display("FAIL reset_counters got=%h/%h exp=0/0", br_cnt, mis_cnt); else passed++;
        rst = 1'b0; out_ready = 1'b0;
    endtask

    task automatic test_blt();
        do_reset();
        set_op(3'd4, 32'hFFFF_FFFF, 32'd1, 32'h100, 32'h20, 1'b0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        total++;
        if (obs !== {1'b1, 1'b1, 32'h120, 1'b1, 1'b1, 1'b0, 1'b0})
            $display("FAIL blt_result got=%h exp=%h", obs, {1'b1, 1'b1, 32'h120, 1'b1, 1'b1, 1'b0, 1'b0});
        else passed++;
    endtask

    task automatic test_bltu();
        do_reset();
        set_op(3'd6, 32'hFFFF_FFFF, 32'd1, 32'h100, 32'h20, 1'b0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        total++;
        if (obs !== {1'b1, 1'b0, 32'h104, 1'b0, 1'b0, 1'b0, 1'b0})
            $display("FAIL bltu_result got=%h exp=%h", obs, {1'b1, 1'b0, 32'h104, 1'b0, 1'b0, 1'b0, 1'b0});
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic [37:0] exp_a, exp_b;
        exp_a = {1'b1, 1'b1, 32'h240, 1'b0, 1'b1, 1'b0, 1'b0};
        exp_b = {1'b1, 1'b1, 32'h310, 1'b1, 1'b0, 1'b1, 1'b0};
        do_reset();
        set_op(3'd1, 32'd1, 32'd2, 32'h200, 32'h40, 1'b1);
        in_valid = 1'b1;
        tick();
        set_op(3'd5, 32'd3, 32'd3, 32'h300, 32'h10, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (in_ready !== 1'b0) $display("FAIL stall_in_ready[%0d] got=%b exp=0", i, in_ready); else passed++;
            tick();
            total++; if (obs !== exp_a) $display("FAIL stall_hold[%0d] got=%h exp=%h", i, obs, exp_a); else passed++;
        end
        out_ready = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) $display("FAIL drain_in_ready got=%b exp=1", in_ready); else passed++;
        tick();
        in_valid = 1'b0;
        total++; if (obs !== exp_b) $display("FAIL reload_no_bubble got=%h exp=%h", obs, exp_b); else passed++;
        total++; if ({br_cnt, mis_cnt} !== {32'd1, 32'd0}) $display("FAIL drain_cnt1 got=%0d/%0d exp=1/0", br_cnt, mis_cnt); else passed++;
        tick();
        total++; if (out_valid !== 1'b0) $display("FAIL drain_empty got=%b exp=0", out_valid); else passed++;
        total++; if ({br_cnt, mis_cnt} !== {32'd2, 32'd1}) $display("FAIL drain_cnt2 got=%0d/%0d exp=2/1", br_cnt, mis_cnt); else passed++;
        out_ready = 1'b0;
    endtask

    task automatic test_wrap();
        do_reset();
        set_op(3'd0, 32'd5, 32'd5, 32'hFFFF_FFFC, 32'd8, 1'b1);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        total++;
        if (obs !== {1'b1, 1'b1, 32'h4, 1'b0, 1'b0, 1'b1, 1'b0})
            $display("FAIL beq_wrap got=%h exp=%h", obs, {1'b1, 1'b1, 32'h4, 1'b0, 1'b0, 1'b1, 1'b0});
        else passed++;
    endtask

    task automatic test_illegal();
        do_reset();
        set_op(3'd2, 32'd1, 32'd2, 32'h400, 32'h80, 1'b1);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        total++;
        if (obs !== {1'b1, 1'b0, 32'h404, 1'b0, 1'b1, 1'b0, 1'b1})
            $display("FAIL illegal_result got=%h exp=%h", obs, {1'b1, 1'b0, 32'h404, 1'b0, 1'b1, 1'b0, 1'b1});
        else passed++;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        total++; if (out_valid !== 1'b0) $display("FAIL illegal_consumed got=%b exp=0", out_valid); else passed++;
        total++; if (br_cnt !== 32'd0) $display("FAIL illegal_br_count got=%0d exp=0", br_cnt); else passed++;
    endtask

    task automatic test_flush();
        do_reset();
        set_op(3'd0, 32'd1, 32'd2, 32'h500, 32'h8, 1'b1);
        in_valid = 1'b1;
        tick();
        flush = 1'b1;
        #1;
        total++; if (in_ready !== 1'b0) $display("FAIL flush_in_ready got=%b exp=0", in_ready); else passed++;
        tick();
        total++; if (out_valid !== 1'b0) $display("FAIL flush_drop got=%b exp=0", out_valid); else passed++;
        total++; if ({br_cnt, mis_cnt} !== 64'd0) $display("FAIL flush_counters got=%0d/%0d exp=0/0", br_cnt, mis_cnt); else passed++;
        flush = 1'b0;
        tick();
        flush = 1'b1; out_ready = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        total++; if (out_valid !== 1'b0) $display("FAIL flush_hs_drop got=%b exp=0", out_valid); else passed++;
        total++; if ({br_cnt, mis_cnt} !== {32'd1, 32'd1}) $display("FAIL flush_hs_counts got=%0d/%0d exp=1/1", br_cnt, mis_cnt); else passed++;
    endtask

    task automatic test_saturate();
        do_reset();
        set_op(3'd0, 32'd0, 32'd1, 32'h600, 32'h10, 1'b1);
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        in_valid = 1'b0;
        tick();
        out_ready = 1'b0;
        total++; if ({br_cnt, mis_cnt} !== {32'd5, 32'd5}) $display("FAIL sat_wide got=%0d/%0d exp=5/5", br_cnt, mis_cnt); else passed++;
        total++; if ({s_br_cnt, s_mis_cnt} !== 4'hF) $display("FAIL sat_narrow got=%0d/%0d exp=3/3", s_br_cnt, s_mis_cnt); else passed++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_op(3'd1, 32'd1, 32'd2, 32'h700, 32'h10, 1'b0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        in_valid = 1'b1; out_ready = 1'b0;
        tick();
        rst = 1'b1; out_ready = 1'b1;
        tick();
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        total++; if (out_valid !== 1'b0) $display("FAIL rstmid_valid got=%b exp=0", out_valid); else passed++;
        total++; if ({br_cnt, mis_cnt} !== 64'd0) $display("FAIL rstmid_counters got=%0d/%0d exp=0/0", br_cnt, mis_cnt); else passed++;
    endtask

    task automatic test_random();
        logic        m_valid, exp_ready, hs;
        logic [36:0] m_ent;
        longint      m_br, m_mis;
        int          errs;
        do_reset();
        m_valid = 1'b0; m_ent = '0; m_br = 0; m_mis = 0; errs = 0;
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            rs1 = $urandom; rs2 = ($urandom_range(0, 3) == 0) ? rs1 : $urandom;
            f3 = 3'($urandom_range(0, 7)); pc = $urandom; imm = $urandom; pred = 1'($urandom);
            #1;
            exp_ready = !flush && (!m_valid || out_ready);
            if (errs < 10) begin
                total++;
                if (in_ready !== exp_ready) begin
                    $display("FAIL rand_in_ready[%0d] got=%b exp=%b", i, in_ready, exp_ready); errs++;
                end else passed++;
            end
            hs = m_valid && out_ready;
            if (hs && !m_ent[0]) begin
                if (m_br < 64'hFFFF_FFFF) m_br++;
                if (m_ent[3] && m_mis < 64'hFFFF_FFFF) m_mis++;
            end
            if (in_valid && exp_ready) begin
                m_valid = 1'b1;
                m_ent   = ref_res(f3, rs1, rs2, pc, imm, pred);
            end else if (flush || hs) m_valid = 1'b0;
            tick();
            if (errs < 10) begin
                total++;
                if (out_valid !== m_valid || br_cnt !== m_br[31:0] || mis_cnt !== m_mis[31:0] ||
                    (m_valid && obs[36:0] !== m_ent)) begin
                    $display("FAIL rand_state[%0d] got v=%b res=%h cnt=%0d/%0d exp v=%b res=%h cnt=%0d/%0d",
                             i, out_valid, obs[36:0], br_cnt, mis_cnt, m_valid, m_ent, m_br, m_mis);
                    errs++;
                end else passed++;
            end
        end
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        set_op(3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
        test_reset();
        test_blt();
        test_bltu();
        test_back_to_back();
        test_wrap();
        test_illegal();
        test_flush();
        test_saturate();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
